// File: rtl/sw_peek_fifo.sv
// sw_peek_fifo: packet FIFO with a two-entry peek window (head, head+1).
// It pops 0, 1 or 2 entries per cycle and uses all DEPTH slots.
// Status flags are decoded from a registered occupancy count.
// Overflow and underflow flags are sticky until reset.
module sw_peek_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     we,
    output logic                     full,
    output logic                     afull,
    input  logic [1:0]               pop,
    output logic [WIDTH-1:0]         out0,
    output logic [WIDTH-1:0]         out1,
    output logic                     v0,
    output logic                     v1,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_udf;

    logic [AW-1:0]    w_rd_ptr_p1;
    logic             w_push_acc;
    logic             w_udf_evt;
    logic [1:0]       w_pop_req;
    logic [1:0]       w_eff_pop;
    logic [CW-1:0]    w_count_next;

    // Status decode from the registered count; the pre-edge count governs push acceptance.
    assign full        = (r_count == CW'(DEPTH));
    assign afull       = (r_count >= CW'(AFULL_TH));
    assign empty       = (r_count == '0);
    assign v0          = (r_count != '0);
    assign v1          = (r_count >= CW'(2));
    assign count       = r_count;
    assign ovf         = r_ovf;
    assign udf         = r_udf;

    // Peek window is read asynchronously; the +1 index wraps naturally at DEPTH.
    assign w_rd_ptr_p1 = r_rd_ptr + AW'(1);
    assign out0        = v0 ? r_mem[r_rd_ptr]    : '0;
    assign out1        = v1 ? r_mem[w_rd_ptr_p1] : '0;

    assign w_push_acc  = we && !full;
    assign w_udf_evt   = (pop == 2'd3) || ({{(CW-2){1'b0}}, pop} > r_count);
    assign w_count_next = r_count + CW'(w_push_acc) - CW'(w_eff_pop);

    // Clamp the pop request: 3 counts as 2, and never pop more than is stored.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_pop_req = pop;
        if (pop == 2'd3) begin
            w_pop_req = 2'd2;
        end
        w_eff_pop = w_pop_req;
        if ({{(CW-2){1'b0}}, w_pop_req} > r_count) begin
            w_eff_pop = r_count[1:0];
        end
    end

    // Storage write on an accepted push; reset only blocks the write in its own cycle.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset; pointers and count alone define what is valid.
        if (!rst && w_push_acc) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointer, occupancy and sticky-flag state; reset discards all contents and requests.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= r_rd_ptr + AW'(w_eff_pop);
            r_count  <= w_count_next;
            if (we && full) begin
                r_ovf <= 1'b1;
            end
            if (w_udf_evt) begin
                r_udf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sw_peek_fifo.sv
// tb_sw_peek_fifo: self-checking bench for sw_peek_fifo (WIDTH=32, DEPTH=16, AFULL_TH=12).
// A queue scoreboard receives a word on every accepted push and gives one up on every pop.
// The peek window and all flags are compared against it once per cycle.
module tb_sw_peek_fifo;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 16;
    localparam int AFULL_TH = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             we = 1'b0;
    logic [1:0]       pop = 2'd0;
    logic             full, afull, v0, v1, empty, ovf, udf;
    logic [WIDTH-1:0] out0, out1;
    logic [4:0]       count;

    logic [WIDTH-1:0] m_q [$];
    bit               m_ovf;
    bit               m_udf;
    int               n_checks;
    int               n_fail;

    sw_peek_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .we(we), .full(full), .afull(afull),
        .pop(pop), .out0(out0), .out1(out1), .v0(v0), .v1(v1), .empty(empty),
        .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare every DUT output against the scoreboard's current contents.
    task automatic compare_state();
        int n;
        n = m_q.size();
        check("count", 64'(count), 64'(n));
        check("empty", 64'(empty), 64'(n == 0));
        check("full",  64'(full),  64'(n == DEPTH));
        check("afull", 64'(afull), 64'(n >= AFULL_TH));
        check("v0",    64'(v0),    64'(n >= 1));
        check("v1",    64'(v1),    64'(n >= 2));
        check("out0",  64'(out0),  (n >= 1) ? 64'(m_q[0]) : 64'd0);
        check("out1",  64'(out1),  (n >= 2) ? 64'(m_q[1]) : 64'd0);
        check("ovf",   64'(ovf),   64'(m_ovf));
        check("udf",   64'(udf),   64'(m_udf));
    endtask

    // One clock cycle: drive, compare at negedge, update the scoreboard, return at posedge+1.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic [1:0] p,
                        input logic r = 1'b0);
        int n;
        int req;
        we      = w;
        in_data = d;
        pop     = p;
        rst     = r;
        @(negedge clk);
        compare_state();
        n = m_q.size();
        if (r) begin
            m_q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            req = (p == 2'd3) ? 2 : int'(p);
            if (p == 2'd3 || int'(p) > n) m_udf = 1;
            if (req > n) req = n;
            for (int i = 0; i < req; i++) void'(m_q.pop_front());
            if (w) begin
                if (n < DEPTH) m_q.push_back(d);
                else m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
        we  = 1'b0;
        pop = 2'd0;
        rst = 1'b0;
    endtask

    task automatic do_reset();
        step(1'b0, '0, 2'd0, 1'b1);
    endtask

    initial begin
        logic [WIDTH-1:0] a, b, c;
        logic [WIDTH-1:0] x [4];
        n_checks = 0;
        n_fail   = 0;

        // Initial reset: the DUT state is unknown before it, so no model compare yet.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_v0",    64'(v0),    64'd0);
        check("rst_v1",    64'(v1),    64'd0);
        check("rst_out0",  64'(out0),  64'd0);
        check("rst_out1",  64'(out1),  64'd0);
        check("rst_full",  64'(full),  64'd0);
        check("rst_afull", 64'(afull), 64'd0);
        check("rst_ovf",   64'(ovf),   64'd0);
        check("rst_udf",   64'(udf),   64'd0);

        // Three pushes, then the peek window holds A and B.
        a = 32'hA000_000A; b = 32'hB000_000B; c = 32'hC000_000C;
        step(1'b1, a, 2'd0);
        step(1'b1, b, 2'd0);
        step(1'b1, c, 2'd0);
        check("t1_count", 64'(count), 64'd3);
        check("t1_out0",  64'(out0),  64'(a));
        check("t1_out1",  64'(out1),  64'(b));
        check("t1_v0v1",  64'({v0, v1}), 64'b11);
        check("t1_empty", 64'(empty), 64'd0);

        // Pop two, then over-pop: underflow sets and occupancy clamps at zero.
        step(1'b0, '0, 2'd2);
        check("t2_out0",  64'(out0),  64'(c));
        check("t2_v1",    64'(v1),    64'd0);
        check("t2_out1",  64'(out1),  64'd0);
        check("t2_count", 64'(count), 64'd1);
        step(1'b0, '0, 2'd2);
        check("t2_count0", 64'(count), 64'd0);
        check("t2_empty",  64'(empty), 64'd1);
        check("t2_udf",    64'(udf),   64'd1);
        step(1'b0, '0, 2'd0);

        // Fill to DEPTH; afull at AFULL_TH, full at DEPTH; push while full with pop=1.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, $urandom, 2'd0);
            check("t3_afull", 64'(afull), 64'(i + 1 >= AFULL_TH));
            check("t3_full",  64'(full),  64'(i + 1 == DEPTH));
        end
        step(1'b1, 32'hDEAD_BEEF, 2'd1);
        check("t3_ovf",   64'(ovf),   64'd1);
        check("t3_count", 64'(count), 64'd15);
        check("t3_full_after", 64'(full), 64'd0);
        step(1'b0, '0, 2'd0);

        // Wrap-around: pointers reach 14, then four pushes wrap wr_ptr.
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b1, $urandom, 2'd0);
        for (int i = 0; i < 14; i++) step(1'b0, '0, 2'd1);
        for (int i = 0; i < 4; i++) begin
            x[i] = 32'h5A00_0000 | 32'(i);
            step(1'b1, x[i], 2'd0);
        end
        check("t4_out0_pre", 64'(out0), 64'(x[0]));
        check("t4_out1_pre", 64'(out1), 64'(x[1]));
        step(1'b0, '0, 2'd2);
        check("t4_out0", 64'(out0), 64'(x[2]));
        check("t4_out1", 64'(out1), 64'(x[3]));
        step(1'b0, '0, 2'd2);
        check("t4_empty", 64'(empty), 64'd1);

        // Push with pop=2 from count=5: occupancy 4, 3, 2, then drain in order.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 2'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, $urandom, 2'd2);
            check("t5_count", 64'(count), 64'(4 - k));
        end
        while (m_q.size() > 0) step(1'b0, '0, 2'd1);
        step(1'b0, '0, 2'd0);

        // Mixed random traffic, including pop=3, checked every cycle.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)));
        end

        // Mid-traffic reset at count=8 with ovf set; the push and pop that cycle are ignored.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 2'd0);
        step(1'b1, 32'h0BAD_0BAD, 2'd0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 2'd2);
        check("t6_pre_count", 64'(count), 64'd8);
        check("t6_pre_ovf",   64'(ovf),   64'd1);
        step(1'b1, 32'h1234_5678, 2'd1, 1'b1);
        check("t6_count", 64'(count), 64'd0);
        check("t6_empty", 64'(empty), 64'd1);
        check("t6_ovf",   64'(ovf),   64'd0);
        check("t6_out0",  64'(out0),  64'd0);
        step(1'b0, '0, 2'd0);
        check("t6_no_push", 64'(count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
